// File: rtl/irq_arbiter_if.sv
// Device-bus register port of the interrupt arbiter: word select, write data/strobe and
// combinational read data.
interface irq_arbiter_if;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;

  modport master (output addr, output wd, output we, input rd);
  modport slave  (input addr, input wd, input we, output rd);
endinterface

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches edge/level requests, masks them, picks the lowest eligible
// index and holds it as a one-hot HWInt until the CPU acks, then waits for EOI.
module irq_arbiter #(
  parameter int unsigned N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  irq_arbiter_if.slave     bus,
  input  logic             int_ack,
  output logic [N_SRC-1:0] HWInt
);

  localparam int unsigned IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] edge_sel_q, edge_sel_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] hwint_q, hwint_d;
  logic [IDW-1:0]   id_q, id_d;

  logic [N_SRC-1:0] elig, rise, w1c, ack_clr;
  logic [IDW-1:0]   win_id;
  logic             any_elig;
  logic             wr_mask, wr_edge, wr_pend, wr_stat;
  logic             wd_unused;

  assign wd_unused = ^bus.wd[31:N_SRC];

  assign wr_mask = bus.we && (bus.addr == 2'd0);
  assign wr_edge = bus.we && (bus.addr == 2'd1);
  assign wr_pend = bus.we && (bus.addr == 2'd2);
  assign wr_stat = bus.we && (bus.addr == 2'd3);

  assign elig     = pend_q & mask_q;
  assign any_elig = |elig;
  assign rise     = irq_in & ~prev_q;
  assign w1c      = wr_pend ? bus.wd[N_SRC-1:0] : '0;
  assign ack_clr  = (state_q == ASSERT && int_ack) ? (N_SRC'(1) << id_q) : '0;

  always_comb begin
    logic found;
    found  = 1'b0;
    win_id = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (elig[i] && !found) begin
        win_id = IDW'(i);
        found  = 1'b1;
      end
    end
  end

  // Edge bits: a fresh rising edge beats any same-cycle clear. Level bits track the line.
  always_comb begin
    mask_d     = wr_mask ? bus.wd[N_SRC-1:0] : mask_q;
    edge_sel_d = wr_edge ? bus.wd[N_SRC-1:0] : edge_sel_q;
    pend_d     = (edge_sel_q & ((pend_q & ~(w1c | ack_clr)) | rise))
               | (~edge_sel_q & irq_in);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    hwint_d = '0;
    unique case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d = ASSERT;
          id_d    = win_id;
        end
      end
      ASSERT: begin
        if (int_ack) begin
          state_d = SERVICE;
        end else if (!elig[id_q]) begin
          state_d = IDLE;
          id_d    = '0;
        end
      end
      SERVICE: begin
        if (wr_stat) begin
          state_d = IDLE;
          id_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        id_d    = '0;
      end
    endcase
    if (state_d == ASSERT) hwint_d = N_SRC'(1) << id_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      id_q       <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
      pend_q     <= '0;
      prev_q     <= '0;
      hwint_q    <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      pend_q     <= pend_d;
      prev_q     <= irq_in;
      hwint_q    <= hwint_d;
    end
  end

  assign HWInt = hwint_q;

  always_comb begin
    bus.rd = '0;
    unique case (bus.addr)
      2'd0: bus.rd = 32'(mask_q);
      2'd1: bus.rd = 32'(edge_sel_q);
      2'd2: bus.rd = 32'(pend_q);
      2'd3: begin
        if (state_q != IDLE) begin
          bus.rd[31]      = 1'b1;
          bus.rd[IDW-1:0] = id_q;
        end
      end
      default: bus.rd = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed vector table, hand-written corner sequences and random
// traffic, all compared against a per-source behavioural model.
module tb_irq_arbiter;
  localparam int N = 6;
  localparam int M_IDLE = 0, M_ASSERT = 1, M_SERVICE = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_in;
  logic         int_ack;
  logic [N-1:0] HWInt;

  irq_arbiter_if bus ();

  irq_arbiter #(.N_SRC(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .bus    (bus),
    .int_ack(int_ack),
    .HWInt  (HWInt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit m_mask[N], m_edge[N], m_pend[N], m_prev[N];
  int m_state, m_id;

  typedef struct {
    logic [N-1:0] irq;
    logic [1:0]   wa;
    logic [31:0]  wd;
    logic         we;
    logic         ack;
    logic [1:0]   ra;
    logic [N-1:0] exp_hw;
    logic [31:0]  exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_mask[i] = 0; m_edge[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
    end
    m_state = M_IDLE;
    m_id    = 0;
  endtask

  function automatic logic [31:0] m_reg(logic [1:0] a);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < N; i++) begin
      if (a == 0) r[i] = m_mask[i];
      if (a == 1) r[i] = m_edge[i];
      if (a == 2) r[i] = m_pend[i];
    end
    if (a == 3) r = (m_state != M_IDLE) ? (32'h8000_0000 + m_id) : 32'h0;
    return r;
  endfunction

  function automatic logic [N-1:0] m_hw();
    return (m_state == M_ASSERT) ? N'(1 << m_id) : '0;
  endfunction

  task automatic m_clock(logic [N-1:0] irq, logic [1:0] wa, logic [31:0] wd, logic we,
                         logic ack);
    bit elig[N];
    int win = -1;
    int ns  = m_state;
    int nid = m_id;
    for (int i = 0; i < N; i++) begin
      elig[i] = m_pend[i] && m_mask[i];
      if (elig[i] && win < 0) win = i;
    end
    if (m_state == M_IDLE && win >= 0) begin
      ns = M_ASSERT; nid = win;
    end else if (m_state == M_ASSERT) begin
      if (ack) ns = M_SERVICE;
      else if (!elig[m_id]) ns = M_IDLE;
    end else if (m_state == M_SERVICE && we && wa == 3) begin
      ns = M_IDLE;
    end
    for (int i = 0; i < N; i++) begin
      if (m_edge[i]) begin
        if (irq[i] && !m_prev[i]) m_pend[i] = 1;
        else if ((we && wa == 2 && wd[i]) || (m_state == M_ASSERT && ack && m_id == i))
          m_pend[i] = 0;
      end else begin
        m_pend[i] = irq[i];
      end
      m_prev[i] = irq[i];
      if (we && wa == 0) m_mask[i] = wd[i];
      if (we && wa == 1) m_edge[i] = wd[i];
    end
    m_state = ns;
    m_id    = nid;
  endtask

  // One clock: drive at negedge, read back register ra just after the edge.
  task automatic step(logic [N-1:0] irq, logic [1:0] wa, logic [31:0] wd, logic we,
                      logic ack, logic [1:0] ra);
    irq_in = irq; bus.addr = wa; bus.wd = wd; bus.we = we; int_ack = ack;
    @(posedge clk);
    m_clock(irq, wa, wd, we, ack);
    #1;
    bus.we = 1'b0; int_ack = 1'b0; bus.addr = ra;
    #1;
    chk("model_hwint", 32'(HWInt), 32'(m_hw()));
    chk("model_rd", bus.rd, m_reg(ra));
    @(negedge clk);
  endtask

  task automatic idle(logic [1:0] ra);
    step(irq_in, 2'd0, 32'h0, 1'b0, 1'b0, ra);
  endtask

  initial begin
    reset = 1'b0; irq_in = '0; int_ack = 1'b0;
    bus.addr = 2'd0; bus.wd = '0; bus.we = 1'b0;
    m_reset();
    #1;
    chk("reset_hwint", 32'(HWInt), 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a);
      #1 chk("reset_rd", bus.rd, 32'h0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // addr 0 MASK, 1 EDGE, 2 PEND, 3 STAT/EOI
    vecs.push_back('{6'h00, 2'd0, 32'h3F, 1'b1, 1'b0, 2'd0, 6'h00, 32'h3F});
    vecs.push_back('{6'h00, 2'd1, 32'h3F, 1'b1, 1'b0, 2'd1, 6'h00, 32'h3F});
    vecs.push_back('{6'h00, 2'd0, 32'h00, 1'b0, 1'b0, 2'd2, 6'h00, 32'h00});
    vecs.push_back('{6'h08, 2'd0, 32'h00, 1'b0, 1'b0, 2'd2, 6'h00, 32'h08});
    vecs.push_back('{6'h00, 2'd0, 32'h00, 1'b0, 1'b0, 2'd2, 6'h08, 32'h08});
    vecs.push_back('{6'h00, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3, 6'h08, 32'h8000_0003});
    vecs.push_back('{6'h00, 2'd0, 32'h00, 1'b0, 1'b1, 2'd2, 6'h00, 32'h00});
    vecs.push_back('{6'h00, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3, 6'h00, 32'h8000_0003});
    vecs.push_back('{6'h00, 2'd3, 32'h00, 1'b1, 1'b0, 2'd3, 6'h00, 32'h00});
    vecs.push_back('{6'h00, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3, 6'h00, 32'h00});
    vecs.push_back('{6'h12, 2'd0, 32'h00, 1'b0, 1'b0, 2'd2, 6'h00, 32'h12});
    vecs.push_back('{6'h00, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3, 6'h02, 32'h8000_0001});
    vecs.push_back('{6'h00, 2'd0, 32'h00, 1'b0, 1'b1, 2'd2, 6'h00, 32'h10});
    vecs.push_back('{6'h00, 2'd3, 32'h00, 1'b1, 1'b0, 2'd3, 6'h00, 32'h00});
    vecs.push_back('{6'h00, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3, 6'h10, 32'h8000_0004});
    vecs.push_back('{6'h00, 2'd0, 32'h00, 1'b0, 1'b1, 2'd2, 6'h00, 32'h00});
    vecs.push_back('{6'h00, 2'd3, 32'h00, 1'b1, 1'b0, 2'd3, 6'h00, 32'h00});

    foreach (vecs[k]) begin
      step(vecs[k].irq, vecs[k].wa, vecs[k].wd, vecs[k].we, vecs[k].ack, vecs[k].ra);
      chk($sformatf("vec%0d_hwint", k), 32'(HWInt), 32'(vecs[k].exp_hw));
      chk($sformatf("vec%0d_rd", k), bus.rd, vecs[k].exp_rd);
    end

    // Level source 2 held through ack and EOI re-asserts; dropping it ends requests.
    step(6'h00, 2'd1, 32'h3B, 1'b1, 1'b0, 2'd1);
    step(6'h04, 2'd0, 32'h00, 1'b0, 1'b0, 2'd2);
    step(6'h04, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3);
    chk("level_assert", 32'(HWInt), 32'h04);
    step(6'h04, 2'd0, 32'h00, 1'b0, 1'b1, 2'd2);
    chk("level_pend_after_ack", bus.rd, 32'h04);
    step(6'h04, 2'd3, 32'h00, 1'b1, 1'b0, 2'd3);
    step(6'h04, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3);
    chk("level_reassert", 32'(HWInt), 32'h04);
    step(6'h00, 2'd0, 32'h00, 1'b0, 1'b1, 2'd2);
    step(6'h00, 2'd3, 32'h00, 1'b1, 1'b0, 2'd3);
    step(6'h00, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3);
    chk("level_dropped", 32'(HWInt), 32'h00);

    // Masking the asserted id withdraws the request but keeps it pending.
    step(6'h00, 2'd1, 32'h3F, 1'b1, 1'b0, 2'd1);
    step(6'h20, 2'd0, 32'h00, 1'b0, 1'b0, 2'd2);
    step(6'h00, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3);
    chk("mask_pre_assert", 32'(HWInt), 32'h20);
    step(6'h00, 2'd0, 32'h1F, 1'b1, 1'b0, 2'd0);
    step(6'h00, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3);
    chk("mask_withdrawn_hw", 32'(HWInt), 32'h00);
    chk("mask_withdrawn_stat", bus.rd, 32'h0);
    idle(2'd2);
    chk("mask_pend_kept", bus.rd, 32'h20);
    step(6'h00, 2'd0, 32'h3F, 1'b1, 1'b0, 2'd0);
    idle(2'd3);
    chk("mask_restored", 32'(HWInt), 32'h20);
    step(6'h00, 2'd0, 32'h00, 1'b0, 1'b1, 2'd2);
    step(6'h00, 2'd3, 32'h00, 1'b1, 1'b0, 2'd3);

    // Edge set beats a same-cycle W1C; W1C alone clears.
    step(6'h00, 2'd0, 32'h00, 1'b1, 1'b0, 2'd0);
    step(6'h01, 2'd2, 32'h01, 1'b1, 1'b0, 2'd2);
    chk("w1c_collision", bus.rd, 32'h01);
    step(6'h00, 2'd2, 32'h3F, 1'b1, 1'b0, 2'd2);
    chk("w1c_clear", bus.rd, 32'h00);

    // Asynchronous reset while in SERVICE.
    step(6'h00, 2'd0, 32'h3F, 1'b1, 1'b0, 2'd0);
    step(6'h01, 2'd0, 32'h00, 1'b0, 1'b0, 2'd2);
    step(6'h00, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3);
    step(6'h00, 2'd0, 32'h00, 1'b0, 1'b1, 2'd3);
    chk("svc_before_reset", bus.rd, 32'h8000_0000);
    #2 reset = 1'b0;
    m_reset();
    #1 chk("async_reset_hwint", 32'(HWInt), 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a);
      #1 chk($sformatf("async_reset_rd%0d", a), bus.rd, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    step(6'h00, 2'd0, 32'h00, 1'b0, 1'b1, 2'd3);
    step(6'h00, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3);
    chk("ack_after_reset_ignored", 32'(HWInt), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [N-1:0] irq;
      logic [1:0]   wa, ra;
      logic [31:0]  wd;
      logic         we, ack;
      irq = N'($urandom) & N'($urandom);
      wa  = 2'($urandom_range(0, 3));
      wd  = $urandom;
      we  = ($urandom_range(0, 4) == 0);
      ack = ($urandom_range(0, 3) == 0);
      ra  = 2'($urandom_range(0, 3));
      step(irq, wa, wd, we, ack, ra);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Interrupt controller between the peripheral devices behind the bridge and the CPU's 6-bit `HWInt` input. It latches raw device requests as edge- or level-triggered, masks them, and selects one winner by fixed priority. It presents the winner to the CPU as a one-hot `HWInt` and holds off further requests until the handler signals end-of-interrupt. Software reaches it through four word registers on the bridge's device bus.

## Interface
- `N_SRC`, default 6: number of interrupt sources. Must equal the `HWInt` width.
- `clk`  in  1: single system clock. All state is updated on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `irq_in`  in  N_SRC: raw device request lines, synchronous to `clk`.
- `addr`  in  2: register word select (byte address bits [3:2]).
- `wd`  in  32: register write data.
- `we`  in  1: register write strobe, decoded by the bridge for this block.
- `rd`  out  32: register read data, combinational from `addr`.
- `int_ack`  in  1: one-cycle pulse from the CPU when it enters the exception handler for a hardware interrupt.
- `HWInt`  out  N_SRC: registered, one-hot request to the CPU, or zero.

## Operation
- Registers. Fields are N_SRC bits wide, zero-extended on read; unused write bits are ignored.
  - `addr`=0, MASK (rw): 1 = source enabled. Reset value 0.
  - `addr`=1, EDGE (rw): 1 = source is edge-triggered (rising edge), 0 = level-triggered. Reset value 0.
  - `addr`=2, PEND (r, write-1-to-clear): latched requests. W1C affects edge sources only.
  - `addr`=3, STAT: read gives bit31 = busy (state ≠ IDLE), bits[2:0] = active source id, 0 when IDLE. Any write is an EOI.
- Pending logic:
  - Edge source: pending bit is set when `irq_in` is 1 and its `prev` copy is 0. The bit is cleared by a W1C write or by `int_ack` for the active id.
  - If set and clear happen in the same cycle, set wins.
  - Level source: the pending bit equals the registered `irq_in`; ack and W1C have no effect on it.
- Eligible set = PEND & MASK. Winner = lowest eligible index (bit 0 has highest priority).
- FSM states:
  - IDLE: `HWInt`=0. If the eligible set is non-empty, latch the winner id and go to ASSERT.
  - ASSERT: `HWInt` = one-hot(id).
    - `int_ack` → SERVICE.
    - If the id becomes ineligible before the ack (masked, or level dropped) → IDLE with `HWInt`=0. This is a withdrawn request.
  - SERVICE: `HWInt`=0. The id is held. A STAT write (EOI) → IDLE.
- `int_ack` is ignored in IDLE and SERVICE. EOI is ignored in IDLE and ASSERT.
- There is no preemption. A higher-priority request arriving in ASSERT or SERVICE waits in PEND.
- Reset: MASK, EDGE, PEND, `prev` and id are cleared to 0; state is IDLE; `HWInt`=0; `rd` reflects the zeroed registers.

## Timing
- Edge source, `irq_in` rising at edge n: PEND bit is visible at n+1; `HWInt` is asserted at n+2 when the source is enabled and the FSM is IDLE.
- Level source: same 2-cycle latency from the first cycle `irq_in` is sampled high.
- `int_ack` sampled at edge k: `HWInt`=0 from k+1. The edge pending bit is clear from k+1.
- EOI written at edge k: IDLE from k+1; the next winner's `HWInt` is asserted at k+2.
- Register write at edge k: the new value is readable at k+1. A MASK change affects arbitration from k+1.
- Reset is asynchronous in the middle of any state: all outputs go to 0 immediately. The first request after release follows the normal latency.

## Test plan
- Reset then MASK=0x3F, EDGE=0x3F. Pulse `irq_in`[3] at cycle 10 → PEND=0x08 at 11, `HWInt`=0x08 at 12. `int_ack` at 15 → `HWInt`=0, PEND=0 at 16, STAT=0x80000003. EOI → STAT=0.
- Edge sources 1 and 4 pulse in the same cycle → `HWInt`=0x02 first. After ack+EOI, `HWInt`=0x10 two cycles after EOI.
- Level source 2 (EDGE bit 2=0) held high through ack and EOI → `HWInt`=0x04 again two cycles after EOI. Drop the line → no further assertion.
- In ASSERT for id 5, write MASK=0x1F → `HWInt`=0 the next cycle, state IDLE, PEND bit 5 remains set. Restore MASK → re-asserted.
- Edge pulse on the same cycle as a W1C write of that bit → PEND bit remains 1. Writing PEND=0x3F while idle with no edges → PEND=0.
- Drop `reset` low while in SERVICE → `HWInt`=0, MASK=EDGE=PEND=0, STAT=0 without waiting for a clock edge. `int_ack` after release is ignored.
